// File: rtl/queue.sv
// Synchronous FIFO queue: data enters at the tail and leaves from the head in
// arrival order, with a registered read port (one-cycle pop latency).
// Optional build macro QUEUE_ERR_FLAGS_EN adds sticky ovf/udf error outputs
// that record dropped pushes and dropped pops until the next reset.
module queue #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] data_out,
    output logic             full,
    output logic             empty,
`ifdef QUEUE_ERR_FLAGS_EN
    output logic             ovf,
    output logic             udf,
`endif
    output logic [depth:0]   count
);

    localparam int entries = 2 ** depth;

    localparam logic [depth:0]   count_cap = {1'b1, {depth{1'b0}}};
    localparam logic [depth:0]   count_one = {{depth{1'b0}}, 1'b1};
    localparam logic [depth-1:0] ptr_one   = {{(depth-1){1'b0}}, 1'b1};

    logic [width-1:0] mem_q [entries];

    logic [depth-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth:0]   count_q, count_d;
    logic [width-1:0] data_out_q, data_out_d;

    logic push_ok;
    logic pop_ok;

`ifdef QUEUE_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
`endif

    // Status flags decoded straight from the registered occupancy count.
    assign full  = (count_q == count_cap);
    assign empty = (count_q == '0);

    // A push is taken when there is room, or when a simultaneous pop frees
    // the head slot at full; a pop is taken only when something is stored,
    // so a push+pop on empty never falls through.
    assign push_ok = en & push & (~full | pop);
    assign pop_ok  = en & pop & ~empty;

    // Next-state computation for pointers, occupancy, read register and flags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ptr_one;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + ptr_one;
            data_out_d = mem_q[rd_ptr_q];
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + count_one;
            2'b01:   count_d = count_q - count_one;
            default: count_d = count_q;
        endcase

`ifdef QUEUE_ERR_FLAGS_EN
        ovf_d = ovf_q | (en & push & ~pop & full);
        udf_d = udf_q | (en & pop & empty);
`endif
    end

    // Control and read-data registers, cleared asynchronously by clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
`ifdef QUEUE_ERR_FLAGS_EN
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
`ifdef QUEUE_ERR_FLAGS_EN
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
`endif
        end
    end

    // Storage write at the tail on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; the
        // pointers and count define which entries are valid.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign count    = count_q;
`ifdef QUEUE_ERR_FLAGS_EN
    assign ovf      = ovf_q;
    assign udf      = udf_q;
`endif

endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue (width=8, depth=2). Stimulus schedules the
// expected data_out value into a scoreboard with the cycle it must appear;
// an independent monitor pops and compares on the falling edge.
module tb_queue;

    logic       clk;
    logic       clr;
    logic       en;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [2:0] count;
`ifdef QUEUE_ERR_FLAGS_EN
    logic       ovf;
    logic       udf;
`endif

    typedef struct {
        int         due;
        logic [7:0] data;
        string      name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        cyc      = 0;
    int        n_checks = 0;
    int        n_errors = 0;

    queue #(.width(8), .depth(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
`ifdef QUEUE_ERR_FLAGS_EN
        .ovf      (ovf),
        .udf      (udf),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare data_out against scheduled expectations.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            if (sb_q[0].due < cyc) begin
                check({sb_q[0].name, "_missed"}, 32'd1, 32'd0);
            end else begin
                check(sb_q[0].name, {24'd0, data_out}, {24'd0, sb_q[0].data});
            end
            void'(sb_q.pop_front());
        end
    end

    // Drive one cycle of inputs (called at a falling edge); optionally
    // schedule the data_out value expected after the coming rising edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d,
                        input logic chk, input logic [7:0] exp, input string name);
        push    = p;
        pop     = q;
        data_in = d;
        if (chk) sb_q.push_back('{due: cyc + 1, data: exp, name: name});
        @(negedge clk);
    endtask

    task automatic status(input string name, input int exp_count);
        check({name, "_count"}, {29'd0, count}, exp_count);
        check({name, "_full"},  {31'd0, full},  (exp_count == 4) ? 1 : 0);
        check({name, "_empty"}, {31'd0, empty}, (exp_count == 0) ? 1 : 0);
    endtask

    initial begin
        clr = 1'b0; en = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;

        // Reset held two cycles.
        repeat (2) @(negedge clk);
        status("in_reset", 0);
        check("in_reset_dout", {24'd0, data_out}, 32'h00);
        clr = 1'b1;
        @(negedge clk);
        status("after_reset", 0);
        check("after_reset_dout", {24'd0, data_out}, 32'h00);

        // Pop on empty: dropped, data_out stays 0.
        step(0, 1, 8'h00, 1, 8'h00, "pop_empty_dout");
        status("pop_empty", 0);
`ifdef QUEUE_ERR_FLAGS_EN
        check("udf_set", {31'd0, udf}, 1);
        check("ovf_clear", {31'd0, ovf}, 0);
`endif

        // Fill to capacity.
        step(1, 0, 8'h11, 0, 8'h00, ""); status("fill1", 1);
        step(1, 0, 8'h22, 0, 8'h00, ""); status("fill2", 2);
        step(1, 0, 8'h33, 0, 8'h00, ""); status("fill3", 3);
        step(1, 0, 8'h44, 0, 8'h00, ""); status("fill4", 4);

        // Push while full is dropped.
        step(1, 0, 8'h55, 0, 8'h00, ""); status("push_full", 4);
`ifdef QUEUE_ERR_FLAGS_EN
        check("ovf_set", {31'd0, ovf}, 1);
`endif

        // Drain in order.
        step(0, 1, 8'h00, 1, 8'h11, "drain_11"); status("drain1", 3);
        step(0, 1, 8'h00, 1, 8'h22, "drain_22"); status("drain2", 2);
        step(0, 1, 8'h00, 1, 8'h33, "drain_33"); status("drain3", 1);
        step(0, 1, 8'h00, 1, 8'h44, "drain_44"); status("drain4", 0);

        // Wrap-around: push-then-pop A0..A5, pointers pass 3 -> 0.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] v;
            v = 8'hA0 + 8'(i);
            step(1, 0, v, 0, 8'h00, "");
            status("wrap_push", 1);
            step(0, 1, 8'h00, 1, v, "wrap_pop");
            status("wrap_pop", 0);
        end

        // Simultaneous push+pop at full.
        step(1, 0, 8'h11, 0, 8'h00, "");
        step(1, 0, 8'h22, 0, 8'h00, "");
        step(1, 0, 8'h33, 0, 8'h00, "");
        step(1, 0, 8'h44, 0, 8'h00, "");
        status("refill", 4);
        step(1, 1, 8'h99, 1, 8'h11, "pp_full_11");
        status("pp_full", 4);
`ifdef QUEUE_ERR_FLAGS_EN
        check("ovf_still_set", {31'd0, ovf}, 1);
`endif
        step(0, 1, 8'h00, 1, 8'h22, "pp_drain_22");
        step(0, 1, 8'h00, 1, 8'h33, "pp_drain_33");
        step(0, 1, 8'h00, 1, 8'h44, "pp_drain_44");
        step(0, 1, 8'h00, 1, 8'h99, "pp_drain_99");
        status("pp_drained", 0);

        // Simultaneous push+pop at empty: push only, no fall-through.
        step(1, 1, 8'h5A, 1, 8'h99, "pp_empty_hold");
        status("pp_empty", 1);
        step(0, 1, 8'h00, 1, 8'h5A, "pp_empty_5a");
        status("pp_empty_pop", 0);

        // Enable low: requests ignored, state holds.
        step(1, 0, 8'h01, 0, 8'h00, "");
        step(1, 0, 8'h02, 0, 8'h00, "");
        step(1, 0, 8'h03, 0, 8'h00, "");
        status("pre_en", 3);
        en = 1'b0;
        step(1, 0, 8'h77, 0, 8'h00, "");
        step(0, 1, 8'h00, 1, 8'h5A, "en0_pop_hold");
        step(1, 1, 8'h78, 1, 8'h5A, "en0_pp_hold");
        status("en0", 3);
        en = 1'b1;
        push = 1'b0; pop = 1'b0;

        // Asynchronous reset between edges with count=3.
        #2 clr = 1'b0;
        #1;
        status("async_rst", 0);
        check("async_rst_dout", {24'd0, data_out}, 32'h00);
`ifdef QUEUE_ERR_FLAGS_EN
        check("async_rst_ovf", {31'd0, ovf}, 0);
        check("async_rst_udf", {31'd0, udf}, 0);
`endif
        @(negedge clk);
        status("rst_held", 0);
        clr = 1'b1;
        step(1, 0, 8'hC3, 0, 8'h00, "");
        status("post_rst_push", 1);
        step(0, 1, 8'h00, 1, 8'hC3, "post_rst_c3");
        status("post_rst_pop", 0);

        // Let the monitor consume remaining expectations.
        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/queue.md
Name: queue

Overview:
- Parameterized synchronous FIFO queue. It is the other-end counterpart of the processor's LIFO stack.
- Data is written at the tail and read back from the head, in arrival order.
- Used between the accumulator datapath and I/O or instruction-prefetch logic where ordering must be preserved.
- Single clock domain; registered read output.

Parameters:
- width, 8, data word width in bits.
- depth, 2, log2 of the number of entries (capacity = 2**depth).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-low reset.
- en  input  1  enable; when 0, push and pop are ignored and all state holds.
- push  input  1  write request; data_in is enqueued at the tail.
- pop  input  1  read request; the head entry is dequeued to data_out.
- data_in  input  width  write data.
- data_out  output  width  registered read data (last popped word).
- full  output  1  1 when count == 2**depth.
- empty  output  1  1 when count == 0.
- count  output  depth+1  number of stored entries, 0..2**depth.

Behaviour:
- Reset: clr=0 asynchronously clears wr_ptr, rd_ptr, count and data_out to 0.
  - full=0, empty=1 during and after reset.
  - Storage array is not cleared; its contents are don't-care.
- All state updates occur on posedge clk while clr=1 and en=1.
- Pointers: wr_ptr and rd_ptr are depth bits wide and wrap modulo 2**depth naturally (2**depth-1 -> 0).
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted pop: data_out <= mem[rd_ptr]; rd_ptr increments.
  - Latency: the popped word is visible on data_out one clock after the pop edge.
  - data_out holds its value until the next accepted pop.
- Acceptance rules:
  - push alone: accepted if full=0, else dropped (no state change).
  - pop alone: accepted if empty=0, else dropped; data_out unchanged.
  - push and pop, 0<count<2**depth: both accepted, count unchanged.
  - push and pop, empty: push accepted, pop dropped; count becomes 1; data_out unchanged. No fall-through.
  - push and pop, full: both accepted; the pop reads the old head, the new word is written to the freed slot; count stays 2**depth.
- count: +1 on push-only accept, -1 on pop-only accept, unchanged otherwise. Never exceeds 2**depth and never underflows.
- full and empty are decoded combinationally from the registered count, with no extra latency.
- Reset mid-operation: all pending state is lost immediately; the queue is empty with no glitch-through of the pop.

Optional Feature:
- Macro QUEUE_ERR_FLAGS_EN.
- Defined:
  - Adds outputs ovf (1 bit) and udf (1 bit), both sticky and cleared only by clr=0.
  - ovf sets on a dropped push (push=1, pop=0, full=1, en=1).
  - udf sets on a dropped pop (pop=1, empty=1, en=1).
  - A push+pop while full never sets ovf. A push+pop while empty sets udf.
- Undefined: ports ovf and udf are absent; dropped requests are silent. Behaviour is otherwise identical.

Test Plan:
- Reset: hold clr=0 two cycles, release -> count=0, empty=1, full=0, data_out=0; a pop while empty leaves data_out=0 (udf=1 if macro defined).
- Fill and order (width=8, depth=2): push 8'h11, 8'h22, 8'h33, 8'h44 -> full=1, count=4. Push 8'h55 -> dropped, count=4 (ovf=1). Pop x4 -> data_out 8'h11, 8'h22, 8'h33, 8'h44, each one cycle after its pop edge; then empty=1.
- Wrap-around: 6 cycles of push-then-pop of 8'hA0..8'hA5 -> every value returns in order; pointers wrap past 3 with no corruption.
- Simultaneous at full: with 8'h11..8'h44 stored, push 8'h99 with pop -> data_out=8'h11, count=4; draining then yields 8'h22, 8'h33, 8'h44, 8'h99.
- Simultaneous at empty: push 8'h5A with pop -> count=1, data_out unchanged; the next pop yields 8'h5A.
- Enable and async reset: en=0 with push/pop toggling -> no change. Assert clr=0 mid-clock with count=3 -> count=0 and empty=1 immediately, before the next edge.
